ofdm_cp_remover: RTL

- Sits directly downstream of the OFDM symbol synchroniser and upstream of the FFT core.
- Consumes the synchronised Avalon-ST sample packet and strips the cyclic prefix from every OFDM symbol.
- Re-frames each FFT_LEN-sample body as its own Avalon-ST packet, with sop on the first body sample and eop on the last.
- A small output FIFO absorbs FFT backpressure, because the upstream stage has no ready signal.

---
 rtl/ofdm_cp_remover.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: strips CP_LEN samples ahead of each body and
// re-frames every FFT_LEN-sample body as its own packet via a small output FIFO.
module ofdm_cp_remover #(
    parameter int FFT_LEN    = 64,
    parameter int CP_LEN     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [31:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic [31:0] aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    output logic        aso_out0_error,
    output logic [15:0] symbol_count,
    output logic        overflow
);

    localparam int MAXL = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
    localparam int CW   = $clog2(MAXL) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CP_LAST   = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] BODY_LAST = CW'(FFT_LEN - 1);

    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          push_req, push_sop, push_eop, push_err, sym_inc;

    logic [34:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, push;
    logic [34:0]   head;

    // A sop beat is CP sample 0; with a one-sample CP the body starts next
    state_t        sop_st;
    logic [CW-1:0] sop_cnt;
    assign sop_st  = (CP_LEN == 1) ? BODY : CP;
    assign sop_cnt = (CP_LEN == 1) ? '0 : CW'(1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        push_req = 1'b0;
        push_sop = 1'b0;
        push_eop = 1'b0;
        push_err = 1'b0;
        sym_inc  = 1'b0;
        if (asi_in0_valid) begin
            unique case (state)
                IDLE: begin
                    if (asi_in0_startofpacket && !asi_in0_endofpacket) begin
                        state_nx = sop_st;
                        cnt_nx   = sop_cnt;
                    end
                end
                CP: begin
                    if (asi_in0_startofpacket) begin
                        state_nx = sop_st;
                        cnt_nx   = sop_cnt;
                    end else if (asi_in0_endofpacket) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CP_LAST) begin
                        state_nx = BODY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                BODY: begin
                    if (asi_in0_startofpacket) begin
                        state_nx = sop_st;
                        cnt_nx   = sop_cnt;
                    end else begin
                        push_req = 1'b1;
                        push_sop = (cnt == '0);
                        push_eop = asi_in0_endofpacket || (cnt == BODY_LAST);
                        push_err = asi_in0_endofpacket && (cnt != BODY_LAST);
                        sym_inc  = (cnt == BODY_LAST);
                        if (asi_in0_endofpacket) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else if (cnt == BODY_LAST) begin
                            state_nx = CP;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && aso_out0_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clock_clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {asi_in0_data, push_sop, push_eop, push_err};
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            symbol_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (sym_inc)
                symbol_count <= symbol_count + 16'd1;
            if (push_req && !push)
                overflow <= 1'b1;
        end
    end

    assign head                   = mem[rd_ptr[AW-1:0]];
    assign aso_out0_valid         = !empty;
    assign aso_out0_data          = empty ? '0 : head[34:3];
    assign aso_out0_startofpacket = !empty && head[2];
    assign aso_out0_endofpacket   = !empty && head[1];
    assign aso_out0_error         = !empty && head[0];

endmodule
